// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline control unit.
package pipe_ctrl_pkg;

    localparam int XLEN  = 64;
    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_ctrl_fwd_unit.sv
// Operand forwarding for one source port: EX/MEM beats writeback, x0 never forwards.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic             i_rs_en,
    input  logic [REG_W-1:0] i_rs_idx,
    input  logic             i_exu_valid,
    input  logic             i_exu_wb_en,
    input  logic             i_exu_load_en,
    input  logic [REG_W-1:0] i_exu_rd,
    input  logic [XLEN-1:0]  i_exu_data,
    input  logic             i_wbu_valid,
    input  logic             i_wbu_wb_en,
    input  logic [REG_W-1:0] i_wbu_rd,
    input  logic [XLEN-1:0]  i_wbu_data,
    output logic             o_fwd_en,
    output logic [XLEN-1:0]  o_fwd_data,
    output logic             o_load_hit
);

    logic w_exu_match;
    logic w_wbu_match;
    logic w_ex_hit;
    logic w_wb_hit;

    assign w_exu_match = i_rs_en & i_exu_valid & (i_exu_rd == i_rs_idx) & (i_exu_rd != '0);
    assign w_wbu_match = i_rs_en & i_wbu_valid & (i_wbu_rd == i_rs_idx) & (i_wbu_rd != '0);

    // A load's value is not ready in EX/MEM; it is reported as a load-use hit instead.
    assign w_ex_hit   = w_exu_match & i_exu_wb_en & ~i_exu_load_en;
    assign w_wb_hit   = w_wbu_match & i_wbu_wb_en;
    assign o_load_hit = w_exu_match & i_exu_load_en;

    assign o_fwd_en   = w_ex_hit | w_wb_hit;
    assign o_fwd_data = w_ex_hit ? i_exu_data : (w_wb_hit ? i_wbu_data : '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: hazard stalls, memory waits, redirect squash, ebreak halt and perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             idu_rs1_en,
    input  logic             idu_rs2_en,
    input  logic [REG_W-1:0] idu_index_rs1,
    input  logic [REG_W-1:0] idu_index_rs2,
    input  logic             exu_valid,
    input  logic             exu_wb_en,
    input  logic             exu_load_en,
    input  logic [REG_W-1:0] exu_index_rd,
    input  logic [XLEN-1:0]  exu_alu_result,
    input  logic             exu_redirect,
    input  logic             exu_ebreak_en,
    input  logic             wbu_valid,
    input  logic             wbu_wb_en,
    input  logic [REG_W-1:0] wbu_index_rd,
    input  logic [XLEN-1:0]  wbu_data,
    input  logic             lsu_busy,
    output logic             instr_valid,
    output logic             flush_nop,
    output logic             front_hold,
    output logic             front_flush,
    output logic             fwd_en_1,
    output logic             fwd_en_2,
    output logic [XLEN-1:0]  fwd_data_rs1,
    output logic [XLEN-1:0]  fwd_data_rs2,
    output logic             halted,
    output logic [CNT_W-1:0] perf_cycles,
    output logic [CNT_W-1:0] perf_stalls,
    output logic [CNT_W-1:0] perf_flushes
);

    localparam logic [1:0]       FLUSH_INIT = 2'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [1:0]       r_flush_cnt;
    logic             r_halted;
    logic [CNT_W-1:0] r_perf_cycles;
    logic [CNT_W-1:0] r_perf_stalls;
    logic [CNT_W-1:0] r_perf_flushes;

    logic             w_rs_en    [2];
    logic [REG_W-1:0] w_rs_idx   [2];
    logic             w_fwd_en   [2];
    logic [XLEN-1:0]  w_fwd_data [2];
    logic             w_load_hit [2];
    logic             w_load_use;
    logic             w_take_redirect;
    logic             w_take_ebreak;
    logic             w_bubble;

    assign w_rs_en[0]  = idu_rs1_en;
    assign w_rs_en[1]  = idu_rs2_en;
    assign w_rs_idx[0] = idu_index_rs1;
    assign w_rs_idx[1] = idu_index_rs2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_unit u_fwd (
                .i_rs_en       (w_rs_en[gi]),
                .i_rs_idx      (w_rs_idx[gi]),
                .i_exu_valid   (exu_valid),
                .i_exu_wb_en   (exu_wb_en),
                .i_exu_load_en (exu_load_en),
                .i_exu_rd      (exu_index_rd),
                .i_exu_data    (exu_alu_result),
                .i_wbu_valid   (wbu_valid),
                .i_wbu_wb_en   (wbu_wb_en),
                .i_wbu_rd      (wbu_index_rd),
                .i_wbu_data    (wbu_data),
                .o_fwd_en      (w_fwd_en[gi]),
                .o_fwd_data    (w_fwd_data[gi]),
                .o_load_hit    (w_load_hit[gi])
            );
        end
    endgenerate

    assign fwd_en_1     = w_fwd_en[0];
    assign fwd_en_2     = w_fwd_en[1];
    assign fwd_data_rs1 = w_fwd_data[0];
    assign fwd_data_rs2 = w_fwd_data[1];
    assign w_load_use   = w_load_hit[0] | w_load_hit[1];

    always_comb begin
        instr_valid     = 1'b1;
        flush_nop       = 1'b0;
        front_hold      = 1'b0;
        front_flush     = 1'b0;
        w_take_redirect = 1'b0;
        w_take_ebreak   = 1'b0;
        w_bubble        = 1'b0;
        case (r_state)
            RUN: begin
                // Memory wait outranks everything so a pending redirect/ebreak lands once it clears.
                if (lsu_busy) begin
                    instr_valid = 1'b0;
                    front_hold  = 1'b1;
                end else if (exu_valid && exu_ebreak_en) begin
                    front_hold    = 1'b1;
                    w_take_ebreak = 1'b1;
                end else if (exu_valid && exu_redirect) begin
                    flush_nop       = 1'b1;
                    front_flush     = 1'b1;
                    w_take_redirect = 1'b1;
                end else if (w_load_use) begin
                    flush_nop  = 1'b1;
                    front_hold = 1'b1;
                    w_bubble   = 1'b1;
                end
            end
            FLUSH: begin
                if (lsu_busy) begin
                    instr_valid = 1'b0;
                    front_hold  = 1'b1;
                end else begin
                    flush_nop = 1'b1;
                end
            end
            HALT: begin
                flush_nop  = 1'b1;
                front_hold = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= RUN;
            r_flush_cnt    <= 2'd0;
            r_halted       <= 1'b0;
            r_perf_cycles  <= '0;
            r_perf_stalls  <= '0;
            r_perf_flushes <= '0;
        end else begin
            if (r_state != HALT)
                r_perf_cycles <= r_perf_cycles + CNT_ONE;
            if (!instr_valid || w_bubble)
                r_perf_stalls <= r_perf_stalls + CNT_ONE;
            if (w_take_redirect)
                r_perf_flushes <= r_perf_flushes + CNT_ONE;

            case (r_state)
                RUN: begin
                    if (w_take_ebreak) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                    end else if (w_take_redirect && FLUSH_CYCLES != 0) begin
                        r_state     <= FLUSH;
                        r_flush_cnt <= FLUSH_INIT;
                    end
                end
                FLUSH: begin
                    if (!lsu_busy) begin
                        if (r_flush_cnt <= 2'd1) begin
                            r_state     <= RUN;
                            r_flush_cnt <= 2'd0;
                        end else begin
                            r_flush_cnt <= r_flush_cnt - 2'd1;
                        end
                    end
                end
                HALT: r_halted <= 1'b1;
                default: r_state <= RUN;
            endcase
        end
    end

    assign halted       = r_halted;
    assign perf_cycles  = r_perf_cycles;
    assign perf_stalls  = r_perf_stalls;
    assign perf_flushes = r_perf_flushes;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl with FLUSH_CYCLES=2.
module tb_pipe_ctrl;

    logic        clk;
    logic        rstn;
    logic        idu_rs1_en, idu_rs2_en;
    logic [4:0]  idu_index_rs1, idu_index_rs2;
    logic        exu_valid, exu_wb_en, exu_load_en;
    logic [4:0]  exu_index_rd;
    logic [63:0] exu_alu_result;
    logic        exu_redirect, exu_ebreak_en;
    logic        wbu_valid, wbu_wb_en;
    logic [4:0]  wbu_index_rd;
    logic [63:0] wbu_data;
    logic        lsu_busy;
    logic        instr_valid, flush_nop, front_hold, front_flush;
    logic        fwd_en_1, fwd_en_2;
    logic [63:0] fwd_data_rs1, fwd_data_rs2;
    logic        halted;
    logic [63:0] perf_cycles, perf_stalls, perf_flushes;

    int n_cmp;
    int n_bad;

    pipe_ctrl #(.FLUSH_CYCLES(2), .CNT_W(64)) dut (
        .clk(clk), .rstn(rstn),
        .idu_rs1_en(idu_rs1_en), .idu_rs2_en(idu_rs2_en),
        .idu_index_rs1(idu_index_rs1), .idu_index_rs2(idu_index_rs2),
        .exu_valid(exu_valid), .exu_wb_en(exu_wb_en), .exu_load_en(exu_load_en),
        .exu_index_rd(exu_index_rd), .exu_alu_result(exu_alu_result),
        .exu_redirect(exu_redirect), .exu_ebreak_en(exu_ebreak_en),
        .wbu_valid(wbu_valid), .wbu_wb_en(wbu_wb_en),
        .wbu_index_rd(wbu_index_rd), .wbu_data(wbu_data),
        .lsu_busy(lsu_busy),
        .instr_valid(instr_valid), .flush_nop(flush_nop),
        .front_hold(front_hold), .front_flush(front_flush),
        .fwd_en_1(fwd_en_1), .fwd_en_2(fwd_en_2),
        .fwd_data_rs1(fwd_data_rs1), .fwd_data_rs2(fwd_data_rs2),
        .halted(halted),
        .perf_cycles(perf_cycles), .perf_stalls(perf_stalls), .perf_flushes(perf_flushes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        idu_rs1_en = 0; idu_rs2_en = 0; idu_index_rs1 = 0; idu_index_rs2 = 0;
        exu_valid = 0; exu_wb_en = 0; exu_load_en = 0; exu_index_rd = 0;
        exu_alu_result = 0; exu_redirect = 0; exu_ebreak_en = 0;
        wbu_valid = 0; wbu_wb_en = 0; wbu_index_rd = 0; wbu_data = 0;
        lsu_busy = 0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rstn = 0;
        repeat (2) @(posedge clk);
        #1 rstn = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rstn = 0;
        #3;
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL rst_halted: got %0b want 0", halted); end
        n_cmp++; if (perf_cycles !== 64'd0) begin n_bad++; $display("FAIL rst_cycles: got %0d want 0", perf_cycles); end
        n_cmp++; if (perf_stalls !== 64'd0) begin n_bad++; $display("FAIL rst_stalls: got %0d want 0", perf_stalls); end
        n_cmp++; if (perf_flushes !== 64'd0) begin n_bad++; $display("FAIL rst_flushes: got %0d want 0", perf_flushes); end
        n_cmp++; if ({instr_valid, flush_nop, front_hold, front_flush} !== 4'b1000) begin
            n_bad++; $display("FAIL rst_ctrl: got %4b want 1000", {instr_valid, flush_nop, front_hold, front_flush}); end
        apply_reset();
        step(); step(); step();
        n_cmp++; if (perf_cycles !== 64'd3) begin n_bad++; $display("FAIL run_cycles: got %0d want 3", perf_cycles); end
        $display("test_reset done: cycles=%0d", perf_cycles);
    endtask

    task automatic test_ex_fwd();
        apply_reset();
        exu_valid = 1; exu_wb_en = 1; exu_index_rd = 5; exu_alu_result = 64'h1234;
        idu_rs1_en = 1; idu_index_rs1 = 5; idu_index_rs2 = 5;
        #1;
        n_cmp++; if (fwd_en_1 !== 1'b1) begin n_bad++; $display("FAIL ex_en1: got %0b want 1", fwd_en_1); end
        n_cmp++; if (fwd_data_rs1 !== 64'h1234) begin n_bad++; $display("FAIL ex_data1: got %0h want 1234", fwd_data_rs1); end
        n_cmp++; if (fwd_en_2 !== 1'b0) begin n_bad++; $display("FAIL ex_en2_gated: got %0b want 0", fwd_en_2); end
        n_cmp++; if (fwd_data_rs2 !== 64'h0) begin n_bad++; $display("FAIL ex_data2_gated: got %0h want 0", fwd_data_rs2); end
        exu_index_rd = 0; idu_index_rs1 = 0;
        #1;
        n_cmp++; if (fwd_en_1 !== 1'b0) begin n_bad++; $display("FAIL ex_x0_en: got %0b want 0", fwd_en_1); end
        n_cmp++; if (fwd_data_rs1 !== 64'h0) begin n_bad++; $display("FAIL ex_x0_data: got %0h want 0", fwd_data_rs1); end
        exu_index_rd = 5; idu_index_rs1 = 5; exu_load_en = 1;
        #1;
        n_cmp++; if (fwd_en_1 !== 1'b0) begin n_bad++; $display("FAIL ex_load_noforward: got %0b want 0", fwd_en_1); end
        n_cmp++; if (flush_nop !== 1'b1) begin n_bad++; $display("FAIL ex_load_use: got %0b want 1", flush_nop); end
        $display("test_ex_fwd done: data1=%0h", fwd_data_rs1);
    endtask

    task automatic test_priority();
        apply_reset();
        exu_valid = 1; exu_wb_en = 1; exu_index_rd = 7; exu_alu_result = 64'hA;
        wbu_valid = 1; wbu_wb_en = 1; wbu_index_rd = 7; wbu_data = 64'hB;
        idu_rs2_en = 1; idu_index_rs2 = 7;
        #1;
        n_cmp++; if (fwd_data_rs2 !== 64'hA) begin n_bad++; $display("FAIL prio_ex: got %0h want a", fwd_data_rs2); end
        exu_valid = 0;
        #1;
        n_cmp++; if (fwd_data_rs2 !== 64'hB) begin n_bad++; $display("FAIL prio_wb: got %0h want b", fwd_data_rs2); end
        n_cmp++; if (fwd_en_2 !== 1'b1) begin n_bad++; $display("FAIL prio_wb_en: got %0b want 1", fwd_en_2); end
        wbu_wb_en = 0;
        #1;
        n_cmp++; if (fwd_en_2 !== 1'b0) begin n_bad++; $display("FAIL prio_none_en: got %0b want 0", fwd_en_2); end
        n_cmp++; if (fwd_data_rs2 !== 64'h0) begin n_bad++; $display("FAIL prio_none_data: got %0h want 0", fwd_data_rs2); end
        $display("test_priority done");
    endtask

    task automatic test_load_use();
        apply_reset();
        exu_valid = 1; exu_wb_en = 1; exu_load_en = 1; exu_index_rd = 3;
        idu_rs1_en = 1; idu_index_rs1 = 3;
        #1;
        n_cmp++; if ({instr_valid, flush_nop, front_hold, front_flush} !== 4'b1110) begin
            n_bad++; $display("FAIL lu_bubble: got %4b want 1110", {instr_valid, flush_nop, front_hold, front_flush}); end
        step();
        exu_valid = 0; exu_load_en = 0; exu_wb_en = 0; exu_index_rd = 0;
        wbu_valid = 1; wbu_wb_en = 1; wbu_index_rd = 3; wbu_data = 64'hBEEF;
        #1;
        n_cmp++; if ({flush_nop, front_hold} !== 2'b00) begin n_bad++; $display("FAIL lu_release: got %2b want 00", {flush_nop, front_hold}); end
        n_cmp++; if (fwd_data_rs1 !== 64'hBEEF) begin n_bad++; $display("FAIL lu_wb_fwd: got %0h want beef", fwd_data_rs1); end
        n_cmp++; if (perf_stalls !== 64'd1) begin n_bad++; $display("FAIL lu_stalls: got %0d want 1", perf_stalls); end
        step();
        clear_inputs();
        exu_valid = 1; exu_wb_en = 1; exu_load_en = 1; exu_index_rd = 0;
        idu_rs1_en = 1; idu_index_rs1 = 0;
        #1;
        n_cmp++; if (flush_nop !== 1'b0) begin n_bad++; $display("FAIL lu_x0: got %0b want 0", flush_nop); end
        n_cmp++; if (perf_stalls !== 64'd1) begin n_bad++; $display("FAIL lu_stalls_hold: got %0d want 1", perf_stalls); end
        $display("test_load_use done: stalls=%0d", perf_stalls);
    endtask

    task automatic test_redirect();
        apply_reset();
        // Redirect coincident with a load-use hazard must squash, not stall.
        exu_valid = 1; exu_redirect = 1; exu_load_en = 1; exu_wb_en = 1; exu_index_rd = 4;
        idu_rs1_en = 1; idu_index_rs1 = 4;
        #1;
        n_cmp++; if ({instr_valid, flush_nop, front_hold, front_flush} !== 4'b1101) begin
            n_bad++; $display("FAIL rd_apply: got %4b want 1101", {instr_valid, flush_nop, front_hold, front_flush}); end
        step();
        clear_inputs();
        #1;
        n_cmp++; if ({instr_valid, flush_nop, front_flush} !== 3'b110) begin
            n_bad++; $display("FAIL rd_flush1: got %3b want 110", {instr_valid, flush_nop, front_flush}); end
        n_cmp++; if (perf_flushes !== 64'd1) begin n_bad++; $display("FAIL rd_flushes: got %0d want 1", perf_flushes); end
        step();
        n_cmp++; if (flush_nop !== 1'b1) begin n_bad++; $display("FAIL rd_flush2: got %0b want 1", flush_nop); end
        step();
        n_cmp++; if (flush_nop !== 1'b0) begin n_bad++; $display("FAIL rd_back_run: got %0b want 0", flush_nop); end
        n_cmp++; if (perf_stalls !== 64'd0) begin n_bad++; $display("FAIL rd_stalls: got %0d want 0", perf_stalls); end
        n_cmp++; if (perf_cycles !== 64'd3) begin n_bad++; $display("FAIL rd_cycles: got %0d want 3", perf_cycles); end
        $display("test_redirect done: flushes=%0d", perf_flushes);
    endtask

    task automatic test_mem_wait();
        apply_reset();
        exu_valid = 1; exu_redirect = 1; lsu_busy = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if ({instr_valid, front_flush, front_hold} !== 3'b001) begin
                n_bad++; $display("FAIL mw_wait%0d: got %3b want 001", i, {instr_valid, front_flush, front_hold}); end
            step();
        end
        lsu_busy = 0;
        #1;
        n_cmp++; if ({instr_valid, flush_nop, front_flush} !== 3'b111) begin
            n_bad++; $display("FAIL mw_apply: got %3b want 111", {instr_valid, flush_nop, front_flush}); end
        n_cmp++; if (perf_stalls !== 64'd3) begin n_bad++; $display("FAIL mw_stalls: got %0d want 3", perf_stalls); end
        step();
        clear_inputs();
        lsu_busy = 1;
        #1;
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL mw_flush_busy: got %0b want 0", instr_valid); end
        step();
        lsu_busy = 0;
        #1;
        n_cmp++; if (flush_nop !== 1'b1) begin n_bad++; $display("FAIL mw_frozen1: got %0b want 1", flush_nop); end
        step();
        n_cmp++; if (flush_nop !== 1'b1) begin n_bad++; $display("FAIL mw_frozen2: got %0b want 1", flush_nop); end
        step();
        n_cmp++; if (flush_nop !== 1'b0) begin n_bad++; $display("FAIL mw_run: got %0b want 0", flush_nop); end
        n_cmp++; if (perf_stalls !== 64'd4) begin n_bad++; $display("FAIL mw_stalls_total: got %0d want 4", perf_stalls); end
        $display("test_mem_wait done: stalls=%0d", perf_stalls);
    endtask

    task automatic test_ebreak();
        apply_reset();
        exu_valid = 1; exu_ebreak_en = 1;
        #1;
        n_cmp++; if ({instr_valid, flush_nop, front_hold, halted} !== 4'b1010) begin
            n_bad++; $display("FAIL eb_apply: got %4b want 1010", {instr_valid, flush_nop, front_hold, halted}); end
        step();
        clear_inputs();
        #1;
        n_cmp++; if ({halted, instr_valid, flush_nop, front_hold} !== 4'b1111) begin
            n_bad++; $display("FAIL eb_halt: got %4b want 1111", {halted, instr_valid, flush_nop, front_hold}); end
        step(); step(); step();
        n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL eb_stay: got %0b want 1", halted); end
        n_cmp++; if (perf_cycles !== 64'd1) begin n_bad++; $display("FAIL eb_cycles_frozen: got %0d want 1", perf_cycles); end
        rstn = 0;
        #1;
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL eb_rst_halted: got %0b want 0", halted); end
        n_cmp++; if (perf_cycles !== 64'd0) begin n_bad++; $display("FAIL eb_rst_cycles: got %0d want 0", perf_cycles); end
        n_cmp++; if ({flush_nop, front_hold} !== 2'b00) begin n_bad++; $display("FAIL eb_rst_ctrl: got %2b want 00", {flush_nop, front_hold}); end
        @(posedge clk); #1 rstn = 1;
        $display("test_ebreak done");
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rstn  = 0;
        clear_inputs();
        test_reset();
        test_ex_fwd();
        test_priority();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_ebreak();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
